// File: rtl/cache_l1_wb_ctrl.sv
// 2-way set-associative write-back, write-allocate L1 controller.
// Single-word lines, LRU replacement, flush scan, saturating counters.
module cache_l1_wb_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int SCN_W = IDX_W + 1;
  localparam logic [SCN_W-1:0] LAST = SCN_W'(2 * SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FLUSH,
    S_INST
  } state_t;

  state_t r_state;

  logic [1:0]        r_valid [SETS];
  logic [1:0]        r_dirty [SETS];
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag   [SETS][2];
  logic [DATA_W-1:0] r_data  [SETS][2];

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_way;
  logic [SCN_W-1:0]  r_scan;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_lset;
  logic [TAG_W-1:0]  w_ltag;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_hit;
  logic              w_hway;
  logic              w_vway;
  logic              w_vdirty;
  logic              w_ack;
  logic [IDX_W-1:0]  w_sset;
  logic              w_sway;
  logic              w_sdirty;

  assign w_idx  = cpu_addr[IDX_W-1:0];
  assign w_tag  = cpu_addr[ADDR_W-1:IDX_W];
  assign w_lset = r_addr[IDX_W-1:0];
  assign w_ltag = r_addr[ADDR_W-1:IDX_W];
  assign w_hit0 = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1 = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  assign w_hway = w_hit1;
  // Invalid ways fill first, way 0 before way 1; otherwise follow LRU.
  assign w_vway = !r_valid[w_idx][0] ? 1'b0 :
                  !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_vdirty = r_valid[w_idx][w_vway] &&
                    r_dirty[w_idx][w_vway];
  assign w_ack  = mem_req & mem_ack;
  assign w_sset = r_scan[SCN_W-1:1];
  assign w_sway = r_scan[0];
  assign w_sdirty = r_valid[w_sset][w_sway] &&
                    r_dirty[w_sset][w_sway];

  assign cpu_ready = (r_state == S_IDLE);

  logic              w_whit;
  logic              w_inst;
  logic              w_fdone;
  logic              w_aw_en;
  logic [IDX_W-1:0]  w_aw_set;
  logic              w_aw_way;
  logic [TAG_W-1:0]  w_aw_tag;
  logic [DATA_W-1:0] w_aw_data;

  assign w_whit  = (r_state == S_IDLE) && cpu_req && !flush &&
                   w_hit && cpu_we;
  assign w_inst  = (r_state == S_INST) ||
                   ((r_state == S_WB) && w_ack && r_we);
  assign w_fdone = (r_state == S_FILL) && w_ack;

  always_comb begin
    w_aw_en   = 1'b0;
    w_aw_set  = w_lset;
    w_aw_way  = r_way;
    w_aw_tag  = w_ltag;
    w_aw_data = r_wdata;
    unique case (1'b1)
      w_whit: begin
        w_aw_en   = 1'b1;
        w_aw_set  = w_idx;
        w_aw_way  = w_hway;
        w_aw_tag  = w_tag;
        w_aw_data = cpu_wdata;
      end
      w_inst: w_aw_en = 1'b1;
      w_fdone: begin
        w_aw_en   = 1'b1;
        w_aw_data = mem_rdata;
      end
      default: ;
    endcase
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clock) begin
    if (w_aw_en) begin
      r_tag[w_aw_set][w_aw_way]  <= w_aw_tag;
      r_data[w_aw_set][w_aw_way] <= w_aw_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= 2'b00;
        r_dirty[s] <= 2'b00;
      end
      r_lru      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_way      <= 1'b0;
      r_scan     <= '0;
      cpu_valid  <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_valid  <= 1'b0;
      cpu_hit    <= 1'b0;
      flush_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH;
            r_scan  <= '0;
          end else if (cpu_req && w_hit) begin
            cpu_valid <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_rdata <= cpu_we ? cpu_wdata :
                         r_data[w_idx][w_hway];
            if (cpu_we) r_dirty[w_idx][w_hway] <= 1'b1;
            r_lru[w_idx] <= ~w_hway;
            if (hit_count != 16'hFFFF)
              hit_count <= hit_count + 16'd1;
          end else if (cpu_req) begin
            if (miss_count != 16'hFFFF)
              miss_count <= miss_count + 16'd1;
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_way   <= w_vway;
            if (w_vdirty) begin
              r_state   <= S_WB;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {r_tag[w_idx][w_vway], w_idx};
              mem_wdata <= r_data[w_idx][w_vway];
            end else if (cpu_we) begin
              r_state <= S_INST;
            end else begin
              r_state  <= S_FILL;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= cpu_addr;
            end
          end
        end
        S_INST: begin
          r_valid[w_lset][r_way] <= 1'b1;
          r_dirty[w_lset][r_way] <= 1'b1;
          r_lru[w_lset]          <= ~r_way;
          cpu_valid              <= 1'b1;
          cpu_rdata              <= r_wdata;
          r_state                <= S_IDLE;
        end
        S_WB: begin
          if (w_ack) begin
            mem_req                <= 1'b0;
            r_dirty[w_lset][r_way] <= 1'b0;
            if (r_we) begin
              r_valid[w_lset][r_way] <= 1'b1;
              r_dirty[w_lset][r_way] <= 1'b1;
              r_lru[w_lset]          <= ~r_way;
              cpu_valid              <= 1'b1;
              cpu_rdata              <= r_wdata;
              r_state                <= S_IDLE;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (w_ack) begin
            mem_req                <= 1'b0;
            r_valid[w_lset][r_way] <= 1'b1;
            r_dirty[w_lset][r_way] <= 1'b0;
            r_lru[w_lset]          <= ~r_way;
            cpu_valid              <= 1'b1;
            cpu_rdata              <= mem_rdata;
            r_state                <= S_IDLE;
          end else if (!mem_req) begin
            // Re-arm after a write-back, leaving one idle cycle.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_addr;
          end
        end
        S_FLUSH: begin
          if (w_ack) begin
            mem_req                  <= 1'b0;
            r_dirty[w_sset][w_sway]  <= 1'b0;
            if (r_scan == LAST) begin
              flush_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_scan <= r_scan + SCN_W'(1);
            end
          end else if (!mem_req) begin
            if (w_sdirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {r_tag[w_sset][w_sway], w_sset};
              mem_wdata <= r_data[w_sset][w_sway];
            end else if (r_scan == LAST) begin
              flush_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_scan <= r_scan + SCN_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_l1_wb_ctrl.sv
// Randomised bench for cache_l1_wb_ctrl against a flat-memory
// plus tag-directory reference model.
module tb_cache_l1_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [15:0] cpu_rdata;
  logic        cpu_hit;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_l1_wb_ctrl #(.ADDR_W(16), .DATA_W(16), .SETS(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .flush(flush), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
  } op_t;

  op_t expq[$];
  op_t obsq[$];
  logic [15:0] bmem [int];
  logic [15:0] gold [int];
  bit hold_ack = 1'b0;

  bit          mv [4][2];
  bit          md [4][2];
  logic [13:0] mt [4][2];
  bit          ml [4];
  int          mhit = 0;
  int          mmiss = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_b(logic [15:0] a);
    return bmem.exists(int'(a)) ? bmem[int'(a)] : (a ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] gval(logic [15:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : (a ^ 16'hA5A5);
  endfunction

  function automatic void m_access(input bit we, input logic [15:0] a,
                                   input logic [15:0] wd,
                                   output bit hit,
                                   output logic [15:0] rd);
    int s;
    int w;
    int v;
    logic [13:0] t;
    logic [15:0] va;
    s = int'(a[1:0]);
    t = a[15:2];
    w = -1;
    for (int i = 0; i < 2; i++)
      if (mv[s][i] && mt[s][i] == t) w = i;
    if (w >= 0) begin
      hit = 1'b1;
      ml[s] = (w == 0);
      if (we) md[s][w] = 1'b1;
      if (mhit < 65535) mhit++;
    end else begin
      hit = 1'b0;
      if (mmiss < 65535) mmiss++;
      v = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : int'(ml[s]));
      if (mv[s][v] && md[s][v]) begin
        va = {mt[s][v], 2'(s)};
        expq.push_back({1'b1, va, gval(va)});
      end
      if (!we) expq.push_back({1'b0, a, 16'h0000});
      mv[s][v] = 1'b1;
      md[s][v] = we;
      mt[s][v] = t;
      ml[s] = (v == 0);
    end
    if (we) gold[int'(a)] = wd;
    rd = gval(a);
  endfunction

  function automatic void m_flush();
    logic [15:0] va;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++)
        if (mv[s][w] && md[s][w]) begin
          va = {mt[s][w], 2'(s)};
          expq.push_back({1'b1, va, gval(va)});
          md[s][w] = 1'b0;
        end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < 4; s++) begin
      ml[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
      end
    end
    gold = bmem;
    mhit = 0;
    mmiss = 0;
    expq.delete();
    obsq.delete();
  endfunction

  int wcnt = 0;
  int ltgt = 0;
  bit spur = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      mem_ack = 1'b0;
      wcnt = 0;
      spur = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      if (!spur) chk("mreq_drop", mem_req, 0);
      spur = 1'b0;
    end else if (mem_req && !hold_ack) begin
      if (wcnt == 0) ltgt = $urandom_range(0, 3);
      if (wcnt >= ltgt) begin
        obsq.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0});
        if (mem_we) bmem[int'(mem_addr)] = mem_wdata;
        mem_rdata = mem_we ? 16'($urandom) : rd_b(mem_addr);
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else if (!mem_req && $urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
      spur = 1'b1;
      mem_rdata = 16'($urandom);
    end
  end

  task automatic cmp_ops(string tag);
    chk({tag, "_nops"}, obsq.size(), expq.size());
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      chk({tag, "_we"}, obsq[i].we, expq[i].we);
      chk({tag, "_addr"}, obsq[i].a, expq[i].a);
      if (expq[i].we) chk({tag, "_wdata"}, obsq[i].d, expq[i].d);
    end
    obsq.delete();
    expq.delete();
  endtask

  task automatic chk_cnt();
    chk("hit_count", hit_count, mhit);
    chk("miss_count", miss_count, mmiss);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) chk("ready_timeout", cpu_ready, 1);
  endtask

  task automatic do_req(input bit we, input logic [15:0] a,
                        input logic [15:0] wd);
    bit eh;
    logic [15:0] er;
    int el;
    int n;
    m_access(we, a, wd, eh, er);
    el = eh ? 1 : ((we && expq.size() == 0) ? 2 : 0);
    wait_ready();
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    @(negedge clock);
    cpu_req = 1'b0;
    n = 1;
    while (!cpu_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("valid", cpu_valid, 1);
    chk("hit", cpu_hit, eh);
    if (!we) chk("rdata", cpu_rdata, er);
    if (el != 0) chk("latency", n, el);
    cmp_ops("req");
    chk_cnt();
  endtask

  task automatic do_flush(input bit with_req);
    int n;
    bit seen_v;
    m_flush();
    wait_ready();
    flush = 1'b1;
    cpu_req = with_req;
    cpu_we = 1'b0;
    cpu_addr = 16'($urandom_range(0, 15));
    @(negedge clock);
    flush = 1'b0;
    cpu_req = 1'b0;
    chk("flush_busy", cpu_ready, 0);
    n = 0;
    seen_v = 1'b0;
    while (!flush_done && n < 400) begin
      @(negedge clock);
      n++;
      if (cpu_valid) seen_v = 1'b1;
    end
    chk("flush_done", flush_done, 1);
    chk("flush_noresp", seen_v, 0);
    cmp_ops("flush");
    chk_cnt();
  endtask

  initial begin
    logic [15:0] ra;
    int n;
    int k;
    repeat (3) @(negedge clock);
    chk("rst_valid", cpu_valid, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_fdone", flush_done, 0);
    chk_cnt();
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", cpu_ready, 1);

    bmem[5] = 16'hBEEF;
    gold[5] = 16'hBEEF;
    do_req(1'b0, 16'h0005, 16'h0);
    do_req(1'b0, 16'h0005, 16'h0);
    do_req(1'b1, 16'h0005, 16'h1234);
    do_req(1'b0, 16'h0009, 16'h0);
    do_req(1'b0, 16'h000D, 16'h0);
    do_req(1'b0, 16'h0009, 16'h0);
    do_req(1'b1, 16'h0002, 16'h00AA);
    do_req(1'b0, 16'h0002, 16'h0);
    do_flush(1'b0);
    do_req(1'b1, 16'h0001, 16'h1111);
    do_req(1'b1, 16'h0006, 16'h6666);
    do_req(1'b0, 16'h0003, 16'h0);
    do_flush(1'b1);
    do_req(1'b0, 16'h0001, 16'h0);
    do_req(1'b0, 16'h0006, 16'h0);
    do_req(1'b0, 16'h0003, 16'h0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else begin
        ra = 16'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) ra[15] = 1'b1;
        do_req(1'($urandom_range(0, 1)), ra, 16'($urandom));
      end
    end

    do_flush(1'b0);
    hold_ack = 1'b1;
    wait_ready();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0104;
    @(negedge clock);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("rst_fill_req", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0104});
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_memreq", mem_req, 0);
    chk("rst_mid_valid", cpu_valid, 0);
    m_reset();
    @(negedge clock);
    reset_n = 1'b1;
    hold_ack = 1'b0;
    @(negedge clock);
    chk("rst_mid_ready", cpu_ready, 1);
    chk_cnt();
    do_req(1'b0, 16'h0104, 16'h0);

    k = 65534 - mhit;
    wait_ready();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0104;
    repeat (k) @(negedge clock);
    cpu_req = 1'b0;
    mhit += k;
    chk("sat_pre", hit_count, 16'hFFFE);
    repeat (3) do_req(1'b0, 16'h0104, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_l1_wb_ctrl.md
# cache_l1_wb_ctrl

Parametrised write-back, write-allocate, 2-way set-associative L1 cache controller with single-word lines. It sits between the CPU-side load/store port and the main-memory or L2 port of the memory hierarchy. Both sides use explicit request/acknowledge handshakes, so memory latency is arbitrary rather than hard-coded delays. It adds LRU replacement, dirty write-back on eviction, a whole-cache flush command and saturating hit/miss counters.

## Interface
- ADDR_W, 16, word-address width
- DATA_W, 16, data word width
- SETS, 4, number of sets; power of two, ≥2; IDX_W = log2(SETS), TAG_W = ADDR_W − IDX_W
- clock  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request; sampled only while cpu_ready=1
- cpu_we  in  1  1=write, 0=read; qualified by cpu_req
- cpu_addr  in  ADDR_W  word address; index=cpu_addr[IDX_W-1:0], tag=cpu_addr[ADDR_W-1:IDX_W]
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  controller can accept a request or flush this cycle
- cpu_valid  out  1  one-cycle pulse; transaction complete
- cpu_rdata  out  DATA_W  read data, valid while cpu_valid=1 for reads
- cpu_hit  out  1  qualifies cpu_valid: 1=L1 hit, 0=miss
- flush  in  1  write back all dirty lines; sampled only while cpu_ready=1
- flush_done  out  1  one-cycle pulse at flush completion
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write-back, 0=fill read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  write-back data
- mem_ack  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  DATA_W  fill data
- hit_count  out  16  saturating count of hits
- miss_count  out  16  saturating count of misses

## Operation
- Per set: 2 ways, each holding valid, dirty, tag and data, plus 1 LRU bit naming the way to replace next.
- States: IDLE, WRITEBACK, FILL, FLUSH. cpu_ready=1 only in IDLE and not in the cycle a miss or flush is accepted.
- IDLE and flush=1: enter FLUSH. flush takes priority over a simultaneous cpu_req; that cpu_req is not accepted.
- IDLE, cpu_req=1 and hit in way w:
  - read returns the data of way w.
  - write updates the data and sets dirty.
  - LRU of the set becomes ~w.
  - hit_count increments.
  - Controller stays in IDLE.
- IDLE, cpu_req=1 and miss:
  - miss_count increments and the request fields are latched.
  - Victim is the first invalid way (way 0 first); otherwise the way named by LRU.
  - Dirty victim: enter WRITEBACK.
  - Clean victim and read: enter FILL.
  - Clean victim and write: install directly (tag, data=cpu_wdata, valid=1, dirty=1), then respond. There is no memory access because the line is one word.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ack, clear victim dirty.
  - Latched read: go to FILL.
  - Latched write: install as above and respond.
- FILL: mem_req=1, mem_we=0, mem_addr=latched address. On mem_ack, install mem_rdata (valid=1, dirty=0), respond with cpu_rdata=mem_rdata, cpu_hit=0, and return to IDLE.
- After any install, LRU = ~victim way.
- FLUSH: a counter scans all ways, 0 … 2·SETS−1, in order (set-major, way 0 first).
  - Dirty valid entry: issue a write-back and wait for mem_ack, then clear dirty. Valid bits and LRU are unchanged.
  - Clean or invalid entry: skip in one cycle.
  - After the last entry: pulse flush_done and return to IDLE.
- mem_ack while mem_req=0 is ignored.
- cpu_req or flush while cpu_ready=0 is ignored. The requester holds its request until it is accepted.
- Counters stop at 16'hFFFF.

## Timing
- Reset (asynchronous assertion) clears:
  - all valid, dirty and LRU bits, counters and state (to IDLE);
  - cpu_valid, cpu_hit, cpu_rdata, flush_done, mem_req, mem_we, mem_addr, mem_wdata (all to 0).
- Reset does not clear tag or data arrays.
- Reset mid-transaction abandons it: mem_req falls immediately, dirty data is lost, no response is given.
- cpu_ready=1 from the first edge after reset_n deasserts.
- Hit: accepted at edge N; cpu_valid=1 and cpu_hit=1 during cycle N+1. Back-to-back hits sustain one per cycle.
- Miss: mem_req rises the cycle after acceptance. cpu_valid pulses in the cycle after the final mem_ack.
- Write miss with clean victim: cpu_valid pulses in cycle N+2.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable until mem_ack. mem_req drops the cycle after mem_ack.
- Between two memory transactions, mem_req is low for at least one cycle.

## Test plan
- Reset, then read 0x0005 with mem_ack after 3 cycles and mem_rdata=0xBEEF -> one fill read at mem_addr 0x0005; cpu_valid with cpu_rdata=0xBEEF and cpu_hit=0; miss_count=1. Reread 0x0005 -> cpu_valid one cycle after accept, cpu_hit=1, 0xBEEF, hit_count=1.
- Write 0x0005=0x1234 after the fill (hit) -> then read 0x0009 (fill way 1) and read 0x000D -> write-back to 0x0005 with data 0x1234, then fill 0x000D; no memory traffic for 0x0009 afterwards.
- Write miss 0x0002=0x00AA into empty set -> no mem_req; cpu_valid two cycles after accept; read 0x0002 hits 0x00AA.
- Dirty lines at 0x0001 and 0x0006 plus clean line 0x0003, assert flush together with cpu_req -> request not accepted; exactly two write-backs (0x0001, then 0x0006); flush_done; rereads of all three addresses hit.
- Assert reset_n low while FILL awaits mem_ack -> mem_req=0 immediately; after release, read of the same address misses again.
- Preload hit_count to 16'hFFFE via 3 hits -> count holds at 16'hFFFF.
